// File: rtl/pipe_controller.sv
// pipe_controller: decode and hazard control for a five-stage MIPS pipeline.
// Build option: define FORWARDING_EN to enable EX operand forwarding.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   opcode_d, funct_d    ID-stage instr[31:26] and instr[5:0]
//   rs_d, rt_d, rd_d     ID-stage register fields
//   zero_e               ALU zero flag from EX
//   stall_f, stall_d     hold PC / hold IF/ID
//   flush_d, flush_e     clear IF/ID / bubble into ID/EX
//   jump_d, pc_src_e     jump taken in ID / branch taken in EX
//   alu_control_e, alu_src_e, reg_dst_e   EX datapath controls
//   fwd_a_e, fwd_b_e     EX operand source (00 rf, 10 EX/MEM, 01 MEM/WB)
//   mem_write_m          MEM store enable
//   reg_write_w, mem_to_reg_w   WB controls
//   illegal_d            unknown opcode/funct in ID
//
// Without FORWARDING_EN any RAW hit on a writer in EX or MEM stalls
// until the writer reaches WB; the register file must write-first.

module pipe_controller #(
    parameter int REG_AW = 5,
    parameter int ALU_CW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        opcode_d,
    input  logic [5:0]        funct_d,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              zero_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic              jump_d,
    output logic              pc_src_e,
    output logic [ALU_CW-1:0] alu_control_e,
    output logic              alu_src_e,
    output logic              reg_dst_e,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              mem_write_m,
    output logic              reg_write_w,
    output logic              mem_to_reg_w,
    output logic              illegal_d
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [REG_AW-1:0] R0 = '0;

    // ---------------- ID decode ----------------
    logic       rw_d, mr_d, mw_d, br_d, as_d, rdst_d, j_d;
    logic       use_rs_d, use_rt_d, ill_d;
    logic [2:0] alu3_d;

    always_comb begin
        rw_d     = 1'b0;
        mr_d     = 1'b0;
        mw_d     = 1'b0;
        br_d     = 1'b0;
        as_d     = 1'b0;
        rdst_d   = 1'b0;
        j_d      = 1'b0;
        use_rs_d = 1'b0;
        use_rt_d = 1'b0;
        ill_d    = 1'b0;
        alu3_d   = 3'b000;
        unique case (opcode_d)
            OP_RTYPE: begin
                unique case (funct_d)
                    FN_ADD:  alu3_d = 3'b010;
                    FN_SUB:  alu3_d = 3'b110;
                    FN_AND:  alu3_d = 3'b000;
                    FN_OR:   alu3_d = 3'b001;
                    FN_SLT:  alu3_d = 3'b111;
                    default: ill_d  = 1'b1;
                endcase
                if (!ill_d) begin
                    rw_d     = 1'b1;
                    rdst_d   = 1'b1;
                    use_rs_d = 1'b1;
                    use_rt_d = 1'b1;
                end
            end
            OP_LW: begin
                rw_d     = 1'b1;
                mr_d     = 1'b1;
                as_d     = 1'b1;
                alu3_d   = 3'b010;
                use_rs_d = 1'b1;
            end
            OP_SW: begin
                mw_d     = 1'b1;
                as_d     = 1'b1;
                alu3_d   = 3'b010;
                use_rs_d = 1'b1;
                use_rt_d = 1'b1;
            end
            OP_BEQ: begin
                br_d     = 1'b1;
                alu3_d   = 3'b110;
                use_rs_d = 1'b1;
                use_rt_d = 1'b1;
            end
            OP_ADDI: begin
                rw_d     = 1'b1;
                as_d     = 1'b1;
                alu3_d   = 3'b010;
                use_rs_d = 1'b1;
            end
            OP_J: begin
                j_d = 1'b1;
            end
            default: ill_d = 1'b1;
        endcase
    end

    assign illegal_d = ill_d;

    // ---------------- ID/EX ----------------
    logic              rw_e, mr_e, mw_e, br_e, as_e, rdst_e;
    logic [2:0]        alu3_e;
    logic [REG_AW-1:0] rt_e, rd_e, wreg_e;

    always_ff @(posedge clk) begin
        if (reset || flush_e) begin
            rw_e   <= 1'b0;
            mr_e   <= 1'b0;
            mw_e   <= 1'b0;
            br_e   <= 1'b0;
            as_e   <= 1'b0;
            rdst_e <= 1'b0;
            alu3_e <= 3'b000;
            rt_e   <= R0;
            rd_e   <= R0;
        end else begin
            rw_e   <= rw_d;
            mr_e   <= mr_d;
            mw_e   <= mw_d;
            br_e   <= br_d;
            as_e   <= as_d;
            rdst_e <= rdst_d;
            alu3_e <= alu3_d;
            // An illegal op carries no register fields, like a bubble.
            rt_e   <= ill_d ? R0 : rt_d;
            rd_e   <= ill_d ? R0 : rd_d;
        end
    end

    assign wreg_e        = rdst_e ? rd_e : rt_e;
    assign alu_control_e = ALU_CW'(alu3_e);
    assign alu_src_e     = as_e;
    assign reg_dst_e     = rdst_e;
    assign pc_src_e      = br_e & zero_e;

    // ---------------- EX/MEM ----------------
    logic              rw_m, mr_m, mw_m;
    logic [REG_AW-1:0] wreg_m;

    always_ff @(posedge clk) begin
        if (reset) begin
            rw_m   <= 1'b0;
            mr_m   <= 1'b0;
            mw_m   <= 1'b0;
            wreg_m <= R0;
        end else begin
            rw_m   <= rw_e;
            mr_m   <= mr_e;
            mw_m   <= mw_e;
            wreg_m <= rw_e ? wreg_e : R0;
        end
    end

    assign mem_write_m = mw_m;

    // ---------------- MEM/WB ----------------
    logic rw_w, mr_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            rw_w <= 1'b0;
            mr_w <= 1'b0;
        end else begin
            rw_w <= rw_m;
            mr_w <= mr_m;
        end
    end

    assign reg_write_w  = rw_w;
    assign mem_to_reg_w = mr_w;

    // ---------------- hazards ----------------
    logic hit_e, hit_m, haz;

    assign hit_e = rw_e && (wreg_e != R0) &&
                   ((use_rs_d && rs_d == wreg_e) ||
                    (use_rt_d && rt_d == wreg_e));

    assign hit_m = rw_m && (wreg_m != R0) &&
                   ((use_rs_d && rs_d == wreg_m) ||
                    (use_rt_d && rt_d == wreg_m));

`ifdef FORWARDING_EN
    logic [REG_AW-1:0] rs_e, wreg_w;

    always_ff @(posedge clk) begin
        if (reset || flush_e) begin
            rs_e <= R0;
        end else begin
            rs_e <= ill_d ? R0 : rs_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wreg_w <= R0;
        end else begin
            wreg_w <= wreg_m;
        end
    end

    // Only a load in EX cannot be forwarded in time.
    assign haz = hit_e & mr_e;

    // EX/MEM is the younger writer, so it takes priority.
    always_comb begin
        fwd_a_e = 2'b00;
        fwd_b_e = 2'b00;
        if (rw_m && wreg_m != R0 && wreg_m == rs_e) begin
            fwd_a_e = 2'b10;
        end else if (rw_w && wreg_w != R0 && wreg_w == rs_e) begin
            fwd_a_e = 2'b01;
        end
        if (rw_m && wreg_m != R0 && wreg_m == rt_e) begin
            fwd_b_e = 2'b10;
        end else if (rw_w && wreg_w != R0 && wreg_w == rt_e) begin
            fwd_b_e = 2'b01;
        end
    end
`else
    logic unused_m;
    assign unused_m = hit_m & 1'b0;

    assign haz     = hit_e | hit_m;
    assign fwd_a_e = 2'b00;
    assign fwd_b_e = 2'b00;
`endif

    // A taken branch flushes ID anyway, so it overrides any stall.
    assign stall_d = haz & ~pc_src_e;
    assign stall_f = stall_d;
    assign flush_e = stall_d | pc_src_e;
    assign jump_d  = j_d & ~stall_d & ~pc_src_e;
    assign flush_d = pc_src_e | jump_d;

endmodule

// File: tb/tb_pipe_controller.sv
// tb_pipe_controller: scoreboard bench for pipe_controller.
// Each row drives one ID instruction and may queue an expected output.

module tb_pipe_controller;

    logic       clk;
    logic       reset;
    logic [5:0] opcode_d, funct_d;
    logic [4:0] rs_d, rt_d, rd_d;
    logic       zero_e;
    logic       stall_f, stall_d, flush_d, flush_e, jump_d, pc_src_e;
    logic [2:0] alu_control_e;
    logic       alu_src_e, reg_dst_e;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic       mem_write_m, reg_write_w, mem_to_reg_w, illegal_d;

    pipe_controller #(.REG_AW(5), .ALU_CW(3)) dut (
        .clk(clk), .reset(reset),
        .opcode_d(opcode_d), .funct_d(funct_d),
        .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
        .zero_e(zero_e),
        .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .flush_e(flush_e),
        .jump_d(jump_d), .pc_src_e(pc_src_e),
        .alu_control_e(alu_control_e),
        .alu_src_e(alu_src_e), .reg_dst_e(reg_dst_e),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .mem_write_m(mem_write_m),
        .reg_write_w(reg_write_w),
        .mem_to_reg_w(mem_to_reg_w),
        .illegal_d(illegal_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [18:0] obs;
    assign obs = {stall_f, stall_d, flush_d, flush_e, jump_d,
                  pc_src_e, alu_control_e, alu_src_e, reg_dst_e,
                  fwd_a_e, fwd_b_e, mem_write_m, reg_write_w,
                  mem_to_reg_w, illegal_d};

    localparam logic [18:0] SF  = 19'h40000;
    localparam logic [18:0] SD  = 19'h20000;
    localparam logic [18:0] FD  = 19'h10000;
    localparam logic [18:0] FE  = 19'h08000;
    localparam logic [18:0] JD  = 19'h04000;
    localparam logic [18:0] PC  = 19'h02000;
    localparam logic [18:0] ALU = 19'h01C00;
    localparam logic [18:0] AS  = 19'h00200;
    localparam logic [18:0] RD  = 19'h00100;
    localparam logic [18:0] FA  = 19'h000C0;
    localparam logic [18:0] FB  = 19'h00030;
    localparam logic [18:0] MW  = 19'h00008;
    localparam logic [18:0] RW  = 19'h00004;
    localparam logic [18:0] MR  = 19'h00002;
    localparam logic [18:0] IL  = 19'h00001;
    localparam logic [18:0] ALL = 19'h7FFFF;
    localparam logic [18:0] STL = SF | SD | FE;

    localparam logic [18:0] A010 = 19'h00800;
    localparam logic [18:0] A110 = 19'h01800;
    localparam logic [18:0] A001 = 19'h00400;
    localparam logic [18:0] A111 = 19'h01C00;
    localparam logic [18:0] FA10 = 19'h00080;
    localparam logic [18:0] FA01 = 19'h00040;
    localparam logic [18:0] FB10 = 19'h00020;

    localparam logic [5:0] R  = 6'h00;
    localparam logic [5:0] J  = 6'h02;
    localparam logic [5:0] BQ = 6'h04;
    localparam logic [5:0] AI = 6'h08;
    localparam logic [5:0] LW = 6'h23;
    localparam logic [5:0] SW = 6'h2B;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        z;
        string       n;
        logic [18:0] m;
        logic [18:0] v;
    } row_t;

    typedef struct {
        string       n;
        logic [18:0] m;
        logic [18:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   failures;

    function automatic row_t mk(string n, logic [5:0] op,
                                logic [5:0] fn, logic [4:0] rs,
                                logic [4:0] rt, logic [4:0] rd,
                                logic z, logic [18:0] m,
                                logic [18:0] v);
        row_t x;
        x.rst = 1'b0;
        x.op  = op;
        x.fn  = fn;
        x.rs  = rs;
        x.rt  = rt;
        x.rd  = rd;
        x.z   = z;
        x.n   = n;
        x.m   = m;
        x.v   = v;
        return x;
    endfunction

    function automatic row_t nop(string n, logic z,
                                 logic [18:0] m, logic [18:0] v);
        return mk(n, BQ, 6'h00, 5'd0, 5'd0, 5'd0, z, m, v);
    endfunction

    task automatic drive(input row_t x);
        @(posedge clk);
        #1;
        reset    = x.rst;
        opcode_d = x.op;
        funct_d  = x.fn;
        rs_d     = x.rs;
        rt_d     = x.rt;
        rd_d     = x.rd;
        zero_e   = x.z;
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) drive(nop("drain", 1'b0, '0, '0));
    endtask

    task automatic test_reset();
        row_t r[$];
        row_t t;
        exp_t e;
        t = mk("rst0", LW, 0, 1, 2, 0, 0, '0, '0);
        t.rst = 1'b1;
        r.push_back(t);
        t = mk("rst_all_zero", LW, 0, 1, 2, 0, 1, ALL, '0);
        t.rst = 1'b1;
        r.push_back(t);
        r.push_back(mk("post_rst_zero", LW, 0, 1, 2, 0, 0, ALL, '0));
        r.push_back(nop("lw_ex", 0, ALU | AS | RD | STL | RW, A010 | AS));
        r.push_back(nop("lw_mem", 0, MW | RW, '0));
        r.push_back(nop("lw_wb", 0, RW | MR, RW | MR));
        r.push_back(mk("mid0", LW, 0, 1, 2, 0, 0, '0, '0));
        t = nop("mid1", 0, '0, '0);
        t.rst = 1'b1;
        r.push_back(t);
        r.push_back(nop("mid_rst_zero", 0, ALL, '0));
        r.push_back(nop("mid_no_wb", 0, RW | MW | MR, '0));
        foreach (r[i]) begin
            drive(r[i]);
            if (r[i].m != '0) sb.push_back(exp_t'{r[i].n, r[i].m, r[i].v});
            @(negedge clk);
            if (r[i].m != '0) begin
                e = sb.pop_front();
                checks++;
                if ((obs & e.m) !== (e.v & e.m)) begin
                    failures++;
                    $display("FAIL %s: got=%05h want=%05h mask=%05h",
                             e.n, obs & e.m, e.v & e.m, e.m);
                end
            end
        end
    endtask

`ifdef FORWARDING_EN
    task automatic test_forwarding();
        row_t r[$];
        exp_t e;
        r.push_back(mk("f_add", R, 6'h20, 1, 2, 3, 0, STL, '0));
        r.push_back(mk("f_sub_nostall", R, 6'h22, 3, 5, 4, 0, STL, '0));
        r.push_back(nop("fwd_a_exmem", 0, FA | FB | ALU | RD,
                        FA10 | A110 | RD));
        r.push_back(mk("f_add2", R, 6'h20, 1, 2, 3, 0, '0, '0));
        r.push_back(nop("f_gap", 0, '0, '0));
        r.push_back(mk("f_sub2", R, 6'h22, 3, 5, 4, 0, '0, '0));
        r.push_back(nop("fwd_a_memwb", 0, FA | FB, FA01));
        r.push_back(mk("f_add0", R, 6'h20, 1, 2, 0, 0, '0, '0));
        r.push_back(mk("f_sub0", R, 6'h22, 0, 5, 4, 0, '0, '0));
        r.push_back(nop("fwd_r0_none", 0, FA | FB, '0));
        r.push_back(mk("f_add3", R, 6'h20, 1, 2, 3, 0, '0, '0));
        r.push_back(mk("f_add4", R, 6'h20, 1, 2, 3, 0, '0, '0));
        r.push_back(mk("f_sub4", R, 6'h22, 5, 3, 4, 0, '0, '0));
        r.push_back(nop("fwd_b_priority", 0, FA | FB, FB10));
        foreach (r[i]) begin
            drive(r[i]);
            if (r[i].m != '0) sb.push_back(exp_t'{r[i].n, r[i].m, r[i].v});
            @(negedge clk);
            if (r[i].m != '0) begin
                e = sb.pop_front();
                checks++;
                if ((obs & e.m) !== (e.v & e.m)) begin
                    failures++;
                    $display("FAIL %s: got=%05h want=%05h mask=%05h",
                             e.n, obs & e.m, e.v & e.m, e.m);
                end
            end
        end
    endtask
`else
    task automatic test_raw_stall();
        row_t r[$];
        exp_t e;
        r.push_back(mk("s_add", R, 6'h20, 1, 2, 3, 0, STL, '0));
        r.push_back(mk("raw_stall1", R, 6'h22, 3, 5, 4, 0,
                       STL | FD | FA | FB, STL));
        r.push_back(mk("raw_stall2", R, 6'h22, 3, 5, 4, 0,
                       STL | FD | FA | FB, STL));
        r.push_back(mk("raw_release", R, 6'h22, 3, 5, 4, 0,
                       STL | FA | FB, '0));
        r.push_back(nop("raw_sub_ex", 0, ALU | RD | FA | STL, A110 | RD));
        r.push_back(mk("s_add0", R, 6'h20, 1, 2, 0, 0, '0, '0));
        r.push_back(mk("raw_r0_nostall", R, 6'h22, 0, 5, 4, 0, STL, '0));
        foreach (r[i]) begin
            drive(r[i]);
            if (r[i].m != '0) sb.push_back(exp_t'{r[i].n, r[i].m, r[i].v});
            @(negedge clk);
            if (r[i].m != '0) begin
                e = sb.pop_front();
                checks++;
                if ((obs & e.m) !== (e.v & e.m)) begin
                    failures++;
                    $display("FAIL %s: got=%05h want=%05h mask=%05h",
                             e.n, obs & e.m, e.v & e.m, e.m);
                end
            end
        end
    endtask
`endif

    task automatic test_load_use();
        row_t r[$];
        exp_t e;
        r.push_back(mk("l_lw", LW, 0, 1, 2, 0, 0, STL, '0));
        r.push_back(mk("lu_stall", R, 6'h20, 2, 5, 4, 0, STL | FD | JD, STL));
`ifdef FORWARDING_EN
        r.push_back(mk("lu_one_cycle", R, 6'h20, 2, 5, 4, 0, STL, '0));
        r.push_back(nop("lu_fwd_memwb", 0, FA | FB | ALU, FA01 | A010));
`else
        r.push_back(mk("lu_stall2", R, 6'h20, 2, 5, 4, 0, STL, STL));
        r.push_back(mk("lu_release", R, 6'h20, 2, 5, 4, 0, STL, '0));
        r.push_back(nop("lu_add_ex", 0, FA | ALU, A010));
`endif
        foreach (r[i]) begin
            drive(r[i]);
            if (r[i].m != '0) sb.push_back(exp_t'{r[i].n, r[i].m, r[i].v});
            @(negedge clk);
            if (r[i].m != '0) begin
                e = sb.pop_front();
                checks++;
                if ((obs & e.m) !== (e.v & e.m)) begin
                    failures++;
                    $display("FAIL %s: got=%05h want=%05h mask=%05h",
                             e.n, obs & e.m, e.v & e.m, e.m);
                end
            end
        end
    endtask

    task automatic test_branch();
        row_t r[$];
        exp_t e;
        r.push_back(mk("b_beq", BQ, 0, 1, 2, 0, 0, STL | FD | PC, '0));
        r.push_back(nop("br_taken", 1, STL | FD | FE | PC | JD | ALU,
                        PC | FD | FE | A110));
        r.push_back(nop("br_bubble", 1, PC | FD | FE | ALU, '0));
        r.push_back(mk("b_beq2", BQ, 0, 1, 2, 0, 0, '0, '0));
        r.push_back(nop("br_not_taken", 0, PC | FD | FE | ALU, A110));
        foreach (r[i]) begin
            drive(r[i]);
            if (r[i].m != '0) sb.push_back(exp_t'{r[i].n, r[i].m, r[i].v});
            @(negedge clk);
            if (r[i].m != '0) begin
                e = sb.pop_front();
                checks++;
                if ((obs & e.m) !== (e.v & e.m)) begin
                    failures++;
                    $display("FAIL %s: got=%05h want=%05h mask=%05h",
                             e.n, obs & e.m, e.v & e.m, e.m);
                end
            end
        end
    endtask

    task automatic test_branch_jump();
        row_t r[$];
        exp_t e;
        r.push_back(mk("x_lw", LW, 0, 1, 2, 0, 0, '0, '0));
        r.push_back(mk("x_beq_stall", BQ, 0, 2, 3, 0, 0, STL | JD, STL));
`ifdef FORWARDING_EN
        r.push_back(mk("x_beq_go", BQ, 0, 2, 3, 0, 0, STL, '0));
`else
        r.push_back(mk("x_beq_stall2", BQ, 0, 2, 3, 0, 0, STL, STL));
        r.push_back(mk("x_beq_go", BQ, 0, 2, 3, 0, 0, STL, '0));
`endif
        r.push_back(mk("br_over_jump", J, 0, 0, 0, 0, 1,
                       STL | FD | FE | PC | JD, PC | FD | FE));
        r.push_back(nop("x_bubble", 0, PC | FD | FE | ALU, '0));
        r.push_back(mk("jump_alone", J, 0, 0, 0, 0, 0,
                       STL | FD | FE | JD | PC, JD | FD));
        r.push_back(nop("jump_done", 0, JD | FD | FE, '0));
        foreach (r[i]) begin
            drive(r[i]);
            if (r[i].m != '0) sb.push_back(exp_t'{r[i].n, r[i].m, r[i].v});
            @(negedge clk);
            if (r[i].m != '0) begin
                e = sb.pop_front();
                checks++;
                if ((obs & e.m) !== (e.v & e.m)) begin
                    failures++;
                    $display("FAIL %s: got=%05h want=%05h mask=%05h",
                             e.n, obs & e.m, e.v & e.m, e.m);
                end
            end
        end
    endtask

    task automatic test_decode();
        row_t r[$];
        exp_t e;
        r.push_back(mk("ill_op", 6'h3F, 0, 2, 3, 4, 0, IL | STL | JD, IL));
        r.push_back(mk("ill_fn", R, 6'h00, 2, 3, 4, 0,
                       IL | ALU | AS | RD, IL));
        r.push_back(mk("sw_id", SW, 0, 1, 2, 0, 0,
                       IL | ALU | AS | RD | MW, '0));
        r.push_back(mk("addi_id", AI, 0, 1, 6, 0, 0,
                       IL | ALU | AS | RD | MW | RW, A010 | AS));
        r.push_back(nop("sw_mem", 0, ALU | AS | RD | MW | RW,
                        A010 | AS | MW));
        r.push_back(nop("sw_wb", 0, MW | RW | MR, '0));
        r.push_back(nop("addi_wb", 0, RW | MR, RW));
        r.push_back(mk("and_id", R, 6'h24, 1, 2, 7, 0, '0, '0));
        r.push_back(mk("and_ex", R, 6'h25, 1, 2, 8, 0,
                       ALU | RD | AS | STL, RD));
        r.push_back(mk("or_ex", R, 6'h2A, 1, 2, 9, 0,
                       ALU | RD | STL, A001 | RD));
        r.push_back(nop("slt_ex", 0, ALU | RD, A111 | RD));
        foreach (r[i]) begin
            drive(r[i]);
            if (r[i].m != '0) sb.push_back(exp_t'{r[i].n, r[i].m, r[i].v});
            @(negedge clk);
            if (r[i].m != '0) begin
                e = sb.pop_front();
                checks++;
                if ((obs & e.m) !== (e.v & e.m)) begin
                    failures++;
                    $display("FAIL %s: got=%05h want=%05h mask=%05h",
                             e.n, obs & e.m, e.v & e.m, e.m);
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        opcode_d = LW;
        funct_d  = 6'h00;
        rs_d     = 5'd0;
        rt_d     = 5'd0;
        rd_d     = 5'd0;
        zero_e   = 1'b0;
        test_reset();
        drain();
`ifdef FORWARDING_EN
        test_forwarding();
`else
        test_raw_stall();
`endif
        drain();
        test_load_use();
        drain();
        test_branch();
        drain();
        test_branch_jump();
        drain();
        test_decode();
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: got=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
